// File: rtl/vga_timing_gen_pkg.sv
// Shared VGA width and 640x480@60 timing constants, plus the timing-set type
// and the acceptance rule used by the configuration handshake.
package vga_timing_gen_pkg;

    localparam int REZ_MAX_WIDTH = 11;

    localparam int VGA_H_TOTAL      = 800;
    localparam int VGA_H_SYNC_START = 656;
    localparam int VGA_H_SYNC_END   = 751;
    localparam int VGA_V_TOTAL      = 525;
    localparam int VGA_V_SYNC_START = 490;
    localparam int VGA_V_SYNC_END   = 491;

    typedef logic [REZ_MAX_WIDTH-1:0] coord_t;

    typedef struct packed {
        coord_t h_total;
        coord_t h_sync_start;
        coord_t h_sync_end;
        coord_t v_total;
        coord_t v_sync_start;
        coord_t v_sync_end;
    } timing_t;

    function automatic logic axis_ok(coord_t total, coord_t sync_start, coord_t sync_end);
        return (total >= coord_t'(2)) && (sync_start <= sync_end) && (sync_end < total);
    endfunction

    function automatic logic timing_ok(timing_t t);
        return axis_ok(t.h_total, t.h_sync_start, t.h_sync_end) &&
               axis_ok(t.v_total, t.v_sync_start, t.v_sync_end);
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Valid/ready timing-set channel from the Config unit to the timing generator.
interface vga_timing_gen_if;
    import vga_timing_gen_pkg::*;

    logic   Cfg_valid;
    logic   Cfg_ready;
    logic   Cfg_err;
    coord_t Cfg_h_total;
    coord_t Cfg_h_sync_start;
    coord_t Cfg_h_sync_end;
    coord_t Cfg_v_total;
    coord_t Cfg_v_sync_start;
    coord_t Cfg_v_sync_end;

    modport master (
        output Cfg_valid, Cfg_h_total, Cfg_h_sync_start, Cfg_h_sync_end,
               Cfg_v_total, Cfg_v_sync_start, Cfg_v_sync_end,
        input  Cfg_ready, Cfg_err
    );

    modport slave (
        input  Cfg_valid, Cfg_h_total, Cfg_h_sync_start, Cfg_h_sync_end,
               Cfg_v_total, Cfg_v_sync_start, Cfg_v_sync_end,
        output Cfg_ready, Cfg_err
    );

endinterface

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping counter plus registered sync, both updated together
// so the sync level never lags the count it describes.
module vga_axis_counter
    import vga_timing_gen_pkg::*;
#(
    parameter bit SYNC_POL = 1'b0
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   i_en,
    input  logic   i_wrap_in,
    input  coord_t i_total,
    input  coord_t i_sync_start,
    input  coord_t i_sync_end,
    output coord_t o_count,
    output logic   o_sync,
    output logic   o_wrap
);

    coord_t r_count;
    logic   r_sync;
    logic   w_step;
    coord_t w_next;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_step = i_en && i_wrap_in;
        o_wrap = w_step && (r_count == i_total - coord_t'(1));
        w_next = o_wrap ? '0 : r_count + coord_t'(1);
    end

    // NOTE: state is assigned with <= so every flop samples pre-edge values, regardless of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
            r_sync  <= ~SYNC_POL;
        end else if (w_step) begin
            r_count <= w_next;
            r_sync  <= ((w_next >= i_sync_start) && (w_next <= i_sync_end)) ? SYNC_POL : ~SYNC_POL;
        end
    end

    assign o_count = r_count;
    assign o_sync  = r_sync;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel-tick divider, h/v axis counters and a pending/active
// timing-set pair so new timings only ever take effect at a frame boundary.
module vga_timing_gen
    import vga_timing_gen_pkg::*;
#(
    parameter int unsigned PIX_DIV          = 4,
    parameter bit          SYNC_POL         = 1'b0,
    parameter int unsigned DEF_H_TOTAL      = VGA_H_TOTAL,
    parameter int unsigned DEF_H_SYNC_START = VGA_H_SYNC_START,
    parameter int unsigned DEF_H_SYNC_END   = VGA_H_SYNC_END,
    parameter int unsigned DEF_V_TOTAL      = VGA_V_TOTAL,
    parameter int unsigned DEF_V_SYNC_START = VGA_V_SYNC_START,
    parameter int unsigned DEF_V_SYNC_END   = VGA_V_SYNC_END
) (
    input  logic                     clk,
    input  logic                     rst_n,
    vga_timing_gen_if.slave          cfg,
    output logic [REZ_MAX_WIDTH-1:0] Count_h,
    output logic [REZ_MAX_WIDTH-1:0] Count_v,
    output logic                     HSYNC,
    output logic                     VSYNC,
    output logic                     Line_start,
    output logic                     Frame_start
);

    localparam int DIV_W = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);

    localparam timing_t DEF_TIMING = '{
        h_total:      coord_t'(DEF_H_TOTAL),
        h_sync_start: coord_t'(DEF_H_SYNC_START),
        h_sync_end:   coord_t'(DEF_H_SYNC_END),
        v_total:      coord_t'(DEF_V_TOTAL),
        v_sync_start: coord_t'(DEF_V_SYNC_START),
        v_sync_end:   coord_t'(DEF_V_SYNC_END)
    };

    logic [DIV_W-1:0] r_div;
    logic             w_tick;

    timing_t r_active;
    timing_t r_pending;
    logic    r_ready;
    logic    r_err;
    logic    r_line_start;
    logic    r_frame_start;

    timing_t w_cfg;
    logic    w_xfer;
    logic    w_apply;
    logic    w_h_wrap;
    logic    w_v_wrap;
    coord_t  w_h_sync_start, w_h_sync_end;
    coord_t  w_v_sync_start, w_v_sync_end;

    assign w_tick = (r_div == DIV_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_div <= '0;
        else        r_div <= w_tick ? '0 : r_div + DIV_W'(1);
    end

    assign w_cfg = '{
        h_total:      cfg.Cfg_h_total,
        h_sync_start: cfg.Cfg_h_sync_start,
        h_sync_end:   cfg.Cfg_h_sync_end,
        v_total:      cfg.Cfg_v_total,
        v_sync_start: cfg.Cfg_v_sync_start,
        v_sync_end:   cfg.Cfg_v_sync_end
    };

    // A held set (ready low) is promoted on the frame-wrap tick; ready low also
    // means a transfer in that same clock cannot happen, so the two never collide.
    assign w_xfer  = cfg.Cfg_valid && r_ready;
    assign w_apply = w_v_wrap && !r_ready;

    // The first pixel of a new frame is judged against the timing it belongs to.
    assign w_h_sync_start = w_apply ? r_pending.h_sync_start : r_active.h_sync_start;
    assign w_h_sync_end   = w_apply ? r_pending.h_sync_end   : r_active.h_sync_end;
    assign w_v_sync_start = w_apply ? r_pending.v_sync_start : r_active.v_sync_start;
    assign w_v_sync_end   = w_apply ? r_pending.v_sync_end   : r_active.v_sync_end;

    // NOTE: the pending slot is a handful of flops, not a RAM, so it is reset like any other register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_active  <= DEF_TIMING;
            r_pending <= '0;
            r_ready   <= 1'b1;
            r_err     <= 1'b0;
        end else begin
            r_err <= w_xfer && !timing_ok(w_cfg);
            if (w_apply) begin
                r_active <= r_pending;
                r_ready  <= 1'b1;
            end else if (w_xfer && timing_ok(w_cfg)) begin
                r_pending <= w_cfg;
                r_ready   <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_line_start  <= w_h_wrap;
            r_frame_start <= w_v_wrap;
        end
    end

    vga_axis_counter #(.SYNC_POL(SYNC_POL)) u_h_axis (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_en         (w_tick),
        .i_wrap_in    (1'b1),
        .i_total      (r_active.h_total),
        .i_sync_start (w_h_sync_start),
        .i_sync_end   (w_h_sync_end),
        .o_count      (Count_h),
        .o_sync       (HSYNC),
        .o_wrap       (w_h_wrap)
    );

    vga_axis_counter #(.SYNC_POL(SYNC_POL)) u_v_axis (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_en         (w_tick),
        .i_wrap_in    (w_h_wrap),
        .i_total      (r_active.v_total),
        .i_sync_start (w_v_sync_start),
        .i_sync_end   (w_v_sync_end),
        .o_count      (Count_v),
        .o_sync       (VSYNC),
        .o_wrap       (w_v_wrap)
    );

    assign Line_start    = r_line_start;
    assign Frame_start   = r_frame_start;
    assign cfg.Cfg_ready = r_ready;
    assign cfg.Cfg_err   = r_err;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: u_dut_a (defaults, tick every clock), u_dut_b (divide by 4,
// active-high sync) and u_dut_c (small 16x8 reset timing for frame-level scenarios).
`timescale 1ns/1ps
module tb_vga_timing_gen;
    import vga_timing_gen_pkg::*;

    localparam int W  = REZ_MAX_WIDTH;
    localparam int VW = 2 * W + 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    vga_timing_gen_if if_a ();
    vga_timing_gen_if if_b ();
    vga_timing_gen_if if_c ();

    logic [W-1:0] a_h, a_v, b_h, b_v, c_h, c_v;
    logic a_hs, a_vs, a_ls, a_fs;
    logic b_hs, b_vs, b_ls, b_fs;
    logic c_hs, c_vs, c_ls, c_fs;
    logic [VW-1:0] a_vec, b_vec, c_vec;

    assign a_vec = {a_h, a_v, a_hs, a_vs, a_ls, a_fs};
    assign b_vec = {b_h, b_v, b_hs, b_vs, b_ls, b_fs};
    assign c_vec = {c_h, c_v, c_hs, c_vs, c_ls, c_fs};

    vga_timing_gen #(.PIX_DIV(1)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .cfg(if_a),
        .Count_h(a_h), .Count_v(a_v), .HSYNC(a_hs), .VSYNC(a_vs),
        .Line_start(a_ls), .Frame_start(a_fs)
    );

    vga_timing_gen #(.PIX_DIV(4), .SYNC_POL(1'b1)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .cfg(if_b),
        .Count_h(b_h), .Count_v(b_v), .HSYNC(b_hs), .VSYNC(b_vs),
        .Line_start(b_ls), .Frame_start(b_fs)
    );

    vga_timing_gen #(
        .PIX_DIV(1), .DEF_H_TOTAL(16), .DEF_H_SYNC_START(12), .DEF_H_SYNC_END(13),
        .DEF_V_TOTAL(8), .DEF_V_SYNC_START(5), .DEF_V_SYNC_END(5)
    ) u_dut_c (
        .clk(clk), .rst_n(rst_n), .cfg(if_c),
        .Count_h(c_h), .Count_v(c_v), .HSYNC(c_hs), .VSYNC(c_vs),
        .Line_start(c_ls), .Frame_start(c_fs)
    );

    // Expected {Count_h, Count_v, HSYNC, VSYNC, Line_start, Frame_start}.
    function automatic logic [VW-1:0] exp_vec(int h, int v, int hss, int hse, int vss, int vse,
                                              bit pol, bit ls, bit fs);
        logic hs, vs;
        hs = (h >= hss && h <= hse) ? pol : ~pol;
        vs = (v >= vss && v <= vse) ? pol : ~pol;
        return {W'(h), W'(v), hs, vs, ls, fs};
    endfunction

    function automatic logic [VW-1:0] exp_c_def(int k);
        return exp_vec(k % 16, (k / 16) % 8, 12, 13, 5, 5, 1'b0, (k % 16) == 0, (k % 128) == 0);
    endfunction

    function automatic timing_t mk(int ht, int hss, int hse, int vt, int vss, int vse);
        timing_t t;
        t.h_total      = coord_t'(ht);
        t.h_sync_start = coord_t'(hss);
        t.h_sync_end   = coord_t'(hse);
        t.v_total      = coord_t'(vt);
        t.v_sync_start = coord_t'(vss);
        t.v_sync_end   = coord_t'(vse);
        return t;
    endfunction

    task automatic offer_a(timing_t t);
        if_a.Cfg_valid        = 1'b1;
        if_a.Cfg_h_total      = t.h_total;
        if_a.Cfg_h_sync_start = t.h_sync_start;
        if_a.Cfg_h_sync_end   = t.h_sync_end;
        if_a.Cfg_v_total      = t.v_total;
        if_a.Cfg_v_sync_start = t.v_sync_start;
        if_a.Cfg_v_sync_end   = t.v_sync_end;
    endtask

    task automatic offer_c(timing_t t);
        if_c.Cfg_valid        = 1'b1;
        if_c.Cfg_h_total      = t.h_total;
        if_c.Cfg_h_sync_start = t.h_sync_start;
        if_c.Cfg_h_sync_end   = t.h_sync_end;
        if_c.Cfg_v_total      = t.v_total;
        if_c.Cfg_v_sync_start = t.v_sync_start;
        if_c.Cfg_v_sync_end   = t.v_sync_end;
    endtask

    // Leaves the bench on the negedge where rst_n rises: sample point k = 0.
    task automatic do_reset();
        if_a.Cfg_valid = 1'b0;
        if_b.Cfg_valid = 1'b0;
        if_c.Cfg_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (a_vec !== exp_vec(0, 0, 656, 751, 490, 491, 1'b0, 1'b0, 1'b0)) begin
            n_fail++; $display("FAIL reset_a: got %h expected %h", a_vec, exp_vec(0, 0, 656, 751, 490, 491, 1'b0, 1'b0, 1'b0));
        end
        n_tests++;
        if (b_vec !== exp_vec(0, 0, 656, 751, 490, 491, 1'b1, 1'b0, 1'b0)) begin
            n_fail++; $display("FAIL reset_b: got %h expected %h", b_vec, exp_vec(0, 0, 656, 751, 490, 491, 1'b1, 1'b0, 1'b0));
        end
        n_tests++;
        if (c_vec !== exp_c_def(1)) begin
            // k=1 would be h=1; reset must show 0,0 with idle syncs and no pulses.
        end
        if (c_vec !== exp_vec(0, 0, 12, 13, 5, 5, 1'b0, 1'b0, 1'b0)) begin
            n_fail++; $display("FAIL reset_c: got %h expected %h", c_vec, exp_vec(0, 0, 12, 13, 5, 5, 1'b0, 1'b0, 1'b0));
        end
        n_tests++;
        if ({if_a.Cfg_ready, if_b.Cfg_ready, if_c.Cfg_ready} !== 3'b111) begin
            n_fail++; $display("FAIL reset_ready: got %b expected 111", {if_a.Cfg_ready, if_b.Cfg_ready, if_c.Cfg_ready});
        end
        n_tests++;
        if ({if_a.Cfg_err, if_b.Cfg_err, if_c.Cfg_err} !== 3'b000) begin
            n_fail++; $display("FAIL reset_err: got %b expected 000", {if_a.Cfg_err, if_b.Cfg_err, if_c.Cfg_err});
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_line_pixdiv1();
        int lows = 0;
        int h, v;
        logic [VW-1:0] e;
        do_reset();
        for (int k = 1; k <= 1601; k++) begin
            @(negedge clk);
            h = k % 800;
            v = k / 800;
            e = exp_vec(h, v, 656, 751, 490, 491, 1'b0, h == 0, 1'b0);
            n_tests++;
            if (a_vec !== e) begin
                n_fail++; $display("FAIL line_a k=%0d: got %h expected %h", k, a_vec, e);
            end
            if (k < 800 && a_hs === 1'b0) lows++;
        end
        n_tests++;
        if (lows !== 96) begin
            n_fail++; $display("FAIL hsync_width_a: got %0d clocks expected 96", lows);
        end
    endtask

    task automatic test_divider();
        int ls_cnt = 0;
        int h, v;
        logic [VW-1:0] e;
        do_reset();
        for (int k = 1; k <= 6401; k++) begin
            @(negedge clk);
            h = (k / 4) % 800;
            v = k / 3200;
            e = exp_vec(h, v, 656, 751, 490, 491, 1'b1, (k % 3200) == 0, 1'b0);
            n_tests++;
            if (b_vec !== e) begin
                n_fail++; $display("FAIL div_b k=%0d: got %h expected %h", k, b_vec, e);
            end
            if (b_ls === 1'b1) ls_cnt++;
        end
        n_tests++;
        if (ls_cnt !== 2) begin
            n_fail++; $display("FAIL line_start_width_b: got %0d high clocks expected 2", ls_cnt);
        end
    endtask

    task automatic test_frame();
        int fs_cnt = 0;
        do_reset();
        for (int k = 1; k <= 260; k++) begin
            @(negedge clk);
            n_tests++;
            if (c_vec !== exp_c_def(k)) begin
                n_fail++; $display("FAIL frame_c k=%0d: got %h expected %h", k, c_vec, exp_c_def(k));
            end
            if (c_fs === 1'b1) fs_cnt++;
        end
        n_tests++;
        if (fs_cnt !== 2) begin
            n_fail++; $display("FAIL frame_start_count_c: got %0d expected 2", fs_cnt);
        end
    endtask

    task automatic test_cfg_midframe();
        int h, v;
        logic [VW-1:0] e;
        do_reset();
        repeat (40) @(negedge clk);
        offer_c(mk(10, 6, 7, 5, 3, 3));
        @(negedge clk);
        if_c.Cfg_valid = 1'b0;
        for (int k = 41; k <= 127; k++) begin
            if (k > 41) @(negedge clk);
            n_tests++;
            if ({c_vec, if_c.Cfg_ready} !== {exp_c_def(k), 1'b0}) begin
                n_fail++; $display("FAIL mid_hold k=%0d: got %h/%b expected %h/0", k, c_vec, if_c.Cfg_ready, exp_c_def(k));
            end
        end
        for (int j = 0; j <= 100; j++) begin
            @(negedge clk);
            h = j % 10;
            v = (j / 10) % 5;
            e = exp_vec(h, v, 6, 7, 3, 3, 1'b0, h == 0, (j % 50) == 0);
            n_tests++;
            if ({c_vec, if_c.Cfg_ready} !== {e, 1'b1}) begin
                n_fail++; $display("FAIL mid_new j=%0d: got %h/%b expected %h/1", j, c_vec, if_c.Cfg_ready, e);
            end
        end
    endtask

    task automatic test_invalid_cfg();
        timing_t bad [6];
        logic [VW-1:0] e;
        bad[0] = mk(800, 656, 900, 525, 490, 491);
        bad[1] = mk(1, 0, 0, 525, 490, 491);
        bad[2] = mk(800, 700, 600, 525, 490, 491);
        bad[3] = mk(800, 656, 800, 525, 490, 491);
        bad[4] = mk(800, 656, 751, 525, 492, 491);
        bad[5] = mk(800, 656, 751, 1, 0, 0);
        do_reset();
        repeat (10) @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            offer_a(bad[i]);
            @(negedge clk);
            if_a.Cfg_valid = 1'b0;
            n_tests++;
            if ({if_a.Cfg_err, if_a.Cfg_ready} !== 2'b11) begin
                n_fail++; $display("FAIL invalid_pulse set=%0d: got err/ready %b expected 11", i, {if_a.Cfg_err, if_a.Cfg_ready});
            end
            @(negedge clk);
            n_tests++;
            if ({if_a.Cfg_err, if_a.Cfg_ready} !== 2'b01) begin
                n_fail++; $display("FAIL invalid_clear set=%0d: got err/ready %b expected 01", i, {if_a.Cfg_err, if_a.Cfg_ready});
            end
        end
        for (int k = 23; k <= 801; k++) begin
            @(negedge clk);
            e = exp_vec(k % 800, k / 800, 656, 751, 490, 491, 1'b0, (k % 800) == 0, 1'b0);
            n_tests++;
            if (a_vec !== e) begin
                n_fail++; $display("FAIL invalid_timing k=%0d: got %h expected %h", k, a_vec, e);
            end
        end
    endtask

    task automatic test_same_clock_wrap();
        int h, v;
        logic [VW-1:0] e;
        do_reset();
        repeat (127) @(negedge clk);
        offer_c(mk(8, 0, 1, 4, 0, 0));
        @(negedge clk);
        if_c.Cfg_valid = 1'b0;
        for (int k = 128; k <= 255; k++) begin
            if (k > 128) @(negedge clk);
            n_tests++;
            if ({c_vec, if_c.Cfg_ready} !== {exp_c_def(k), 1'b0}) begin
                n_fail++; $display("FAIL wrap_old k=%0d: got %h/%b expected %h/0", k, c_vec, if_c.Cfg_ready, exp_c_def(k));
            end
        end
        for (int j = 0; j <= 40; j++) begin
            @(negedge clk);
            h = j % 8;
            v = (j / 8) % 4;
            e = exp_vec(h, v, 0, 1, 0, 0, 1'b0, h == 0, (j % 32) == 0);
            n_tests++;
            if ({c_vec, if_c.Cfg_ready} !== {e, 1'b1}) begin
                n_fail++; $display("FAIL wrap_new j=%0d: got %h/%b expected %h/1", j, c_vec, if_c.Cfg_ready, e);
            end
        end
    endtask

    task automatic test_reset_midframe();
        do_reset();
        repeat (40) @(negedge clk);
        offer_c(mk(10, 6, 7, 5, 3, 3));
        @(negedge clk);
        if_c.Cfg_valid = 1'b0;
        n_tests++;
        if (if_c.Cfg_ready !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_pending: got ready %b expected 0", if_c.Cfg_ready);
        end
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({c_vec, if_c.Cfg_ready} !== {exp_vec(0, 0, 12, 13, 5, 5, 1'b0, 1'b0, 1'b0), 1'b1}) begin
            n_fail++; $display("FAIL rstmid_async: got %h/%b expected %h/1", c_vec, if_c.Cfg_ready, exp_vec(0, 0, 12, 13, 5, 5, 1'b0, 1'b0, 1'b0));
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 150; k++) begin
            @(negedge clk);
            n_tests++;
            if ({c_vec, if_c.Cfg_ready} !== {exp_c_def(k), 1'b1}) begin
                n_fail++; $display("FAIL rstmid_resume k=%0d: got %h/%b expected %h/1", k, c_vec, if_c.Cfg_ready, exp_c_def(k));
            end
        end
    endtask

    initial begin
        if_a.Cfg_valid = 1'b0;
        if_b.Cfg_valid = 1'b0;
        if_c.Cfg_valid = 1'b0;
        offer_a(mk(0, 0, 0, 0, 0, 0));
        offer_c(mk(0, 0, 0, 0, 0, 0));
        if_a.Cfg_valid        = 1'b0;
        if_c.Cfg_valid        = 1'b0;
        if_b.Cfg_h_total      = '0;
        if_b.Cfg_h_sync_start = '0;
        if_b.Cfg_h_sync_end   = '0;
        if_b.Cfg_v_total      = '0;
        if_b.Cfg_v_sync_start = '0;
        if_b.Cfg_v_sync_end   = '0;

        test_reset();
        test_line_pixdiv1();
        test_divider();
        test_frame();
        test_cfg_midframe();
        test_invalid_cfg();
        test_same_clock_wrap();
        test_reset_midframe();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Produces the raster counters and sync pulses that drive the VGA output path: Count_h/Count_v to the colour-assignment stage, plus HSYNC/VSYNC to the connector. Timing values come from the Config unit through a valid/ready handshake. Each accepted timing set is held as pending and made live only at a frame boundary, so a frame is never torn. A pixel-tick divider derives the pixel rate from the system clock.

Parameters:
REZ_MAX_WIDTH, 11, width of all counters and timing values
PIX_DIV, 4, system clocks per pixel (100 MHz -> 25 MHz); 1 = tick every clock
SYNC_POL, 0, active level of HSYNC/VSYNC (0 = active-low, VGA 640x480)
DEF_H_TOTAL, 800, reset horizontal total
DEF_H_SYNC_START, 656, reset HSYNC first pixel
DEF_H_SYNC_END, 751, reset HSYNC last pixel
DEF_V_TOTAL, 525, reset vertical total
DEF_V_SYNC_START, 490, reset VSYNC first line
DEF_V_SYNC_END, 491, reset VSYNC last line

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
Cfg_valid  in  1  new timing set offered
Cfg_ready  out  1  block can accept a timing set
Cfg_h_total, Cfg_h_sync_start, Cfg_h_sync_end  in  REZ_MAX_WIDTH each  horizontal timing
Cfg_v_total, Cfg_v_sync_start, Cfg_v_sync_end  in  REZ_MAX_WIDTH each  vertical timing
Cfg_err  out  1  one-clock pulse: offered set rejected
Count_h  out  REZ_MAX_WIDTH  current pixel column
Count_v  out  REZ_MAX_WIDTH  current line
HSYNC  out  1  horizontal sync
VSYNC  out  1  vertical sync
Line_start  out  1  one-clock pulse when Count_h becomes 0
Frame_start  out  1  one-clock pulse when Count_h and Count_v both become 0

Behaviour:
- Reset (async, rst_n=0):
  - Count_h=0, Count_v=0, HSYNC=VSYNC=~SYNC_POL.
  - Line_start=Frame_start=Cfg_err=0, Cfg_ready=1.
  - Divider=0; active timing = DEF_* parameters; pending slot empty.
- Reset mid-frame or mid-handshake discards the pending set. Counting restarts at 0,0 on the first tick after release.
- Tick divider:
  - div counts 0..PIX_DIV-1; tick=1 in the clock where div==PIX_DIV-1, then div wraps to 0.
  - PIX_DIV=1: tick every clock.
- Counters (update only on tick, all outputs registered):
  - Count_h increments.
  - At Count_h==h_total-1: Count_h->0 and Count_v increments.
  - At Count_v==v_total-1 together with the h wrap: Count_v->0 (frame wrap).
- Sync:
  - HSYNC=SYNC_POL iff the new Count_h is in [h_sync_start, h_sync_end], else ~SYNC_POL.
  - VSYNC likewise on Count_v.
  - Both are computed from the next counter values and registered on the same edge as the counters, giving zero skew versus the counts.
- Pulses: Line_start/Frame_start are high exactly one clock, the clock in which the registered counters show the wrapped value. They are not stretched to PIX_DIV clocks.
- Config handshake:
  - Transfer occurs when Cfg_valid && Cfg_ready.
  - Validity check at transfer: total>=2, sync_start<=sync_end, sync_end<total, for both axes.
  - Invalid set: Cfg_err=1 next clock, set discarded, Cfg_ready stays 1.
  - Valid set: stored in pending, Cfg_ready=0 from next clock.
  - On the next frame-wrap tick, pending -> active and Cfg_ready returns to 1 the following clock. Sync for the new frame's first pixel already uses the new values.
  - Transfer in the same clock as a frame-wrap tick: the set is stored but not applied until the following wrap.
- Cfg_valid while Cfg_ready=0 is ignored. The Config unit must hold its inputs stable until Cfg_ready rises.
- Width rule: all comparisons are unsigned over REZ_MAX_WIDTH. Counters can never exceed total-1, because a new total only takes effect at 0,0.

Decomposition:
- Shared package/include (existing VGA width-parameter include): REZ_MAX_WIDTH and the DEF_* 640x480@60 timing constants.
- Sub-module vga_axis_counter, instantiated twice (h and v):
  - Inputs: enable, wrap-in, total, sync_start, sync_end.
  - Outputs: count, sync, wrap-out.
  - The v instance is enabled by the h wrap-out.

Test Plan:
1. PIX_DIV=1, defaults, release reset:
   - Count_h reaches 799 then 0 with Line_start=1 in that clock.
   - HSYNC=0 for exactly Count_h 656..751 (96 clocks).
   - Frame_start every 420000 clocks.
2. PIX_DIV=4:
   - Count_h changes every 4th clock.
   - One line = 3200 clocks; Line_start width = 1 clock.
3. Mid-frame valid config (h_total=10, hsync 6..7, v_total=5, vsync 3..3):
   - Cfg_ready low until the frame wrap, then high.
   - Following frame = 50 ticks; HSYNC low at Count_h 6,7.
4. Invalid config (h_sync_end=900, h_total=800):
   - Cfg_err pulses once, Cfg_ready stays 1.
   - Timing is unchanged.
5. Config transfer in the same clock as a frame-wrap tick:
   - Current frame keeps the old values.
   - New values apply at the next wrap.
6. Assert rst_n=0 at Count_h=300, Count_v=200 with a pending set:
   - Outputs reset immediately, Cfg_ready=1.
   - After release, default timing resumes from 0,0.
